door_code_sender: RTL and testbench
===================================

Name: door_code_sender

Overview:
Transmit side of the door-lock keypad interface. On a start pulse it replays a stored N-digit code onto the one-hot button bus that the door lock receives, one press per digit, with a configurable gap after each press. It then watches the lock's green/red LEDs and reports pass, fail or timeout. It is used as an automatic dialer for bring-up and board self-test, and as a stimulus engine for lock regression.

Parameters:
NUM_DIGITS, 4, digits per code (≥1)
HOLD_CYCLES, 1, cycles each button stays asserted (≥1)
GAP_CYCLES, 0, all-zero cycles after each press (0 = back-to-back presses)
TIMEOUT, 10, max cycles waited for an LED verdict after the last press (≥1)
RST_CYCLES, 2, length of the door_rs pulse (used only with AUTO_RESET_EN)

Ports:
clk  in  1  system clock, rising edge
rs  in  1  asynchronous active-low reset
start  in  1  single-cycle request; accepted only while busy=0
code  in  2*NUM_DIGITS  digit i in bits [2i+1:2i]; digit 0 is sent first; value k drives btn bit k
btn  out  4  one-hot button bus to the lock (bit0 = button 1 … bit3 = button 4)
led_green  in  1  lock "unlocked" indicator
led_red  in  1  lock "error" indicator
door_rs  out  1  active-high reset pulse to the lock (driven only with AUTO_RESET_EN; otherwise constant 0)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when a result is valid
result  out  2  00 none, 01 pass, 10 fail, 11 timeout; held until the next accepted start

Behaviour:
- Reset (rs=0, async): state IDLE; btn=0, door_rs=0, busy=0, done=0, result=00, all counters 0. Deassertion is synchronous to clk by construction upstream.
- States: IDLE, LOCK_RST (macro only), PRESS, GAP, WAIT_RES, DONE.
- IDLE: start=1 latches code into a shift register, clears result to 00, sets busy, and moves to PRESS (or LOCK_RST with the macro). start while busy is ignored with no side effects.
- PRESS: btn = 1<<digit[i] (registered output). The first press appears on the cycle after start. Hold for HOLD_CYCLES cycles. Then go to GAP if GAP_CYCLES>0; otherwise go to the next digit's PRESS, or to WAIT_RES after the last digit.
- GAP: btn=0 for GAP_CYCLES cycles. Then go to the next PRESS, or to WAIT_RES after the last digit.
- WAIT_RES: btn=0. LEDs are sampled each cycle from the first WAIT_RES cycle onward.
  - led_green=1 and led_red=0 → result=01.
  - led_red=1, including when both LEDs are high → result=10.
  - Neither LED seen within TIMEOUT cycles → result=11.
- DONE: done=1 for exactly one cycle; busy drops in the same cycle; return to IDLE. A start in the DONE cycle is ignored.
- Digit counter width is clog2(NUM_DIGITS). The shared timer counter is sized for max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT, RST_CYCLES). Counters never wrap mid-phase.
- btn is never non-one-hot. It is all-zero outside PRESS.
- LED activity during PRESS/GAP is ignored; only WAIT_RES decides the result.
- An rs assertion mid-sequence aborts immediately: btn=0, no done, result=00.

Optional Feature:
AUTO_RESET_EN
- Defined: start enters LOCK_RST, which drives door_rs=1 for RST_CYCLES cycles with btn=0, followed by one idle cycle, then PRESS of digit 0.
- Undefined: the LOCK_RST state and its logic are absent, door_rs is tied 0, and start goes directly to PRESS.

Decomposition:
- Package door_pkg holds:
  - State enum.
  - Result codes RES_NONE/RES_PASS/RES_FAIL/RES_TIMEOUT.
  - BTN_W=4 and DIGIT_W=2 constants.
  - Digit-to-one-hot function.
- Sub-module: door_phase_timer, a loadable down-counter with a zero flag, shared by the PRESS, GAP, WAIT_RES and LOCK_RST phases.

Test Plan:
- Reset: rs=0 with random inputs → btn=0, busy=0, done=0, result=00; state is IDLE after release.
- code=8'hD8 (digits 0,2,1,3), defaults, lock model accepts 1-3-2-4 → btn cycles 0001,0100,0010,1000 on consecutive clocks, then 0000; led_green rises → done pulse with result=01.
- code=8'hE4 (1-2-3-4 order), lock model raises led_red → btn 0001,0010,0100,1000; result=10.
- LEDs held low → done exactly 10 cycles after the last press; result=11.
- HOLD_CYCLES=2, GAP_CYCLES=1 → each button high 2 cycles, then 1 zero cycle.
- Start during busy and rs pulled low mid-press → both starts ignored; abort gives btn=0 and no done. With AUTO_RESET_EN, door_rs=1 for 2 cycles before the first press.

Source files
------------

// File: rtl/door_pkg.sv
// rtl/door_pkg.sv - shared states, result codes and helpers for the door code sender
// Contents: state_t FSM encoding, RES_* result codes, BTN_W/DIGIT_W widths,
//           digit_onehot() digit-to-button mapping, max_int() for sizing.
// Optional: AUTO_RESET_EN adds the LOCK_RST state.
package door_pkg;

    localparam int BTN_W   = 4;
    localparam int DIGIT_W = 2;

    typedef enum logic [2:0] {
        IDLE,
`ifdef AUTO_RESET_EN
        LOCK_RST,
`endif
        PRESS,
        GAP,
        WAIT_RES,
        DONE
    } state_t;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_PASS    = 2'b01;
    localparam logic [1:0] RES_FAIL    = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    // Digit value k lights button bit k.
    function automatic logic [BTN_W-1:0] digit_onehot(input logic [DIGIT_W-1:0] d);
        return {{(BTN_W-1){1'b0}}, 1'b1} << d;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/door_phase_timer.sv
// rtl/door_phase_timer.sv - loadable down-counter with zero flag shared by all timed phases
// Ports: clk, rs (async active-low reset), load/load_val (load has priority),
//        zero (count has reached 0; counter then holds at 0 and never wraps).
module door_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rs,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/door_code_sender.sv
// rtl/door_code_sender.sv - replays a stored code onto the lock keypad bus and reports the verdict
// Ports: clk, rs (async active-low reset), start (accepted only while idle),
//        code (digit i in bits [2i+1:2i], digit 0 sent first), btn (one-hot keypad bus),
//        led_green/led_red (lock verdict), door_rs (lock reset pulse), busy, done (1-cycle),
//        result (00 none, 01 pass, 10 fail, 11 timeout; held until the next accepted start).
// Optional: define AUTO_RESET_EN to pulse door_rs for RST_CYCLES (plus one quiet cycle)
//           before the first press; otherwise door_rs is tied low.
module door_code_sender #(
    parameter int NUM_DIGITS  = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 0,
    parameter int TIMEOUT     = 10,
    parameter int RST_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    rs,
    input  logic                    start,
    input  logic [2*NUM_DIGITS-1:0] code,
    output logic [3:0]              btn,
    input  logic                    led_green,
    input  logic                    led_red,
    output logic                    door_rs,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              result
);

    import door_pkg::*;

    localparam int CW   = 2 * NUM_DIGITS;
    localparam int DCW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMAX = max_int(max_int(HOLD_CYCLES, GAP_CYCLES), max_int(TIMEOUT, RST_CYCLES));
    localparam int TW   = $clog2(TMAX + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      shreg_q, shreg_d;
    logic [DCW-1:0]     dcnt_q, dcnt_d;
    logic [1:0]         result_q, result_d;
    logic [BTN_W-1:0]   btn_q;
    logic               busy_q, done_q;
    logic               tmr_load, tmr_zero;
    logic [TW-1:0]      tmr_val;
    logic               step;
    logic               last_digit;

    assign last_digit = (dcnt_q == DCW'(NUM_DIGITS - 1));

    door_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rs       (rs),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Phase lengths are loaded as N-1 so that a phase lasts N cycles, the
    // last of which is the one where the timer reads zero.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        dcnt_d   = dcnt_q;
        result_d = result_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        step     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d  = code;
                    dcnt_d   = '0;
                    result_d = RES_NONE;
                    tmr_load = 1'b1;
`ifdef AUTO_RESET_EN
                    // Loaded with the full length: the extra zero cycle is the
                    // quiet cycle between the lock reset and the first press.
                    state_d  = LOCK_RST;
                    tmr_val  = TW'(RST_CYCLES);
`else
                    state_d  = PRESS;
                    tmr_val  = TW'(HOLD_CYCLES - 1);
`endif
                end
            end
`ifdef AUTO_RESET_EN
            LOCK_RST: begin
                if (tmr_zero) begin
                    state_d  = PRESS;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(HOLD_CYCLES - 1);
                end
            end
`endif
            PRESS: begin
                if (tmr_zero) begin
                    if (GAP_CYCLES > 0) begin
                        state_d  = GAP;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(GAP_CYCLES - 1);
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    step = 1'b1;
                end
            end
            WAIT_RES: begin
                // Red wins when both LEDs are lit.
                if (led_red) begin
                    result_d = RES_FAIL;
                    state_d  = DONE;
                end else if (led_green) begin
                    result_d = RES_PASS;
                    state_d  = DONE;
                end else if (tmr_zero) begin
                    result_d = RES_TIMEOUT;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Advance to the next digit, or start listening after the last one.
        if (step) begin
            tmr_load = 1'b1;
            if (last_digit) begin
                state_d = WAIT_RES;
                tmr_val = TW'(TIMEOUT - 1);
            end else begin
                state_d = PRESS;
                shreg_d = shreg_q >> DIGIT_W;
                dcnt_d  = dcnt_q + 1'b1;
                tmr_val = TW'(HOLD_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            dcnt_q   <= '0;
            result_q <= RES_NONE;
            btn_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            dcnt_q   <= dcnt_d;
            result_q <= result_d;
            // Outputs follow the next state so they line up with it cycle-for-cycle.
            btn_q    <= (state_d == PRESS) ? digit_onehot(shreg_d[DIGIT_W-1:0]) : '0;
            busy_q   <= (state_d != IDLE) && (state_d != DONE);
            done_q   <= (state_d == DONE);
        end
    end

`ifdef AUTO_RESET_EN
    assign door_rs = (state_q == LOCK_RST) && !tmr_zero;
`else
    assign door_rs = 1'b0;
`endif

    assign btn    = btn_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_door_code_sender.sv
// tb/tb_door_code_sender.sv - scoreboard bench for door_code_sender (default and gapped builds)
// Optional: AUTO_RESET_EN expects the door_rs pulse ahead of the first press.
module tb_door_code_sender;

    import door_pkg::*;

    localparam int TIMEOUT_CYC = 10;
    localparam int RST_CYC     = 2;
    localparam int LAT         = 2;
    localparam logic [15:0] LOCK_KEY = 16'h1428;

    localparam int LK_JUDGE = 0;
    localparam int LK_MUTE  = 1;
    localparam int LK_BOTH  = 2;
    localparam int LK_NOISE = 3;
    localparam int LK_RAND  = 4;

    logic       clk   = 1'b0;
    logic       rs    = 1'b0;
    logic       start = 1'b0;
    logic       sel   = 1'b0;
    logic [7:0] code  = 8'h00;
    logic       led_g = 1'b0;
    logic       led_r = 1'b0;

    logic       start0, start1, led_g0, led_r0, led_g1, led_r1;
    logic [3:0] btn0, btn1, btn_s;
    logic       door_rs0, door_rs1, door_rs_s;
    logic       busy0, busy1, busy_s;
    logic       done0, done1, done_s;
    logic [1:0] result0, result1, result_s;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] exp_trace[$];
    logic [1:0] exp_res[$];

    int          lk_mode  = LK_JUDGE;
    logic        lk_clear = 1'b1;
    logic [15:0] lk_seq;
    logic [3:0]  lk_prev;
    int          lk_n;
    int          lk_zc;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign led_g0 = led_g & ~sel;
    assign led_r0 = led_r & ~sel;
    assign led_g1 = led_g & sel;
    assign led_r1 = led_r & sel;

    assign btn_s     = sel ? btn1     : btn0;
    assign door_rs_s = sel ? door_rs1 : door_rs0;
    assign busy_s    = sel ? busy1    : busy0;
    assign done_s    = sel ? done1    : done0;
    assign result_s  = sel ? result1  : result0;

    door_code_sender dut0 (
        .clk(clk), .rs(rs), .start(start0), .code(code), .btn(btn0),
        .led_green(led_g0), .led_red(led_r0), .door_rs(door_rs0),
        .busy(busy0), .done(done0), .result(result0)
    );

    door_code_sender #(.HOLD_CYCLES(2), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rs(rs), .start(start1), .code(code), .btn(btn1),
        .led_green(led_g1), .led_red(led_r1), .door_rs(door_rs1),
        .busy(busy1), .done(done1), .result(result1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Lock model: records distinct presses, then after LAT quiet cycles lights
    // an LED according to the mode.
    always @(posedge clk) begin
        #2;
        if (lk_clear) begin
            lk_seq = '0; lk_prev = '0; lk_n = 0; lk_zc = 0;
            led_g = 1'b0; led_r = 1'b0;
        end else if (lk_mode == LK_RAND) begin
            led_g = 1'($urandom);
            led_r = 1'($urandom);
        end else begin
            if (btn_s != 4'b0 && btn_s != lk_prev) begin
                lk_seq = {lk_seq[11:0], btn_s};
                lk_n++;
            end
            lk_prev = btn_s;
            if (lk_mode == LK_NOISE) led_r = (btn_s != 4'b0);
            if (lk_n == 4 && btn_s == 4'b0) lk_zc++;
            if (lk_zc == LAT) begin
                case (lk_mode)
                    LK_JUDGE: if (lk_seq == LOCK_KEY) led_g = 1'b1; else led_r = 1'b1;
                    LK_BOTH:  begin led_g = 1'b1; led_r = 1'b1; end
                    LK_NOISE: led_g = 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    task automatic run_seq(input string name, input bit s, input logic [7:0] c, input int mode,
                           input logic [1:0] er, input bit poke, input bit abort);
        int hold, gap, idx, waits, n;
        bit bad;
        logic [4:0] e;
        logic [1:0] er_q;
        hold = s ? 2 : 1;
        gap  = s ? 1 : 0;
        sel = s; lk_mode = mode; lk_clear = 1'b1;
        @(negedge clk);
        lk_clear = 1'b0;
        exp_trace.delete();
`ifdef AUTO_RESET_EN
        for (int i = 0; i < RST_CYC; i++) exp_trace.push_back(5'b1_0000);
        exp_trace.push_back(5'b0_0000);
`endif
        for (int d = 0; d < 4; d++) begin
            for (int h = 0; h < hold; h++) exp_trace.push_back({1'b0, 4'b0001 << c[2*d +: 2]});
            for (int g = 0; g < gap; g++) exp_trace.push_back(5'b0_0000);
        end
        exp_res.push_back(er);
        code = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; code = 8'($urandom);
        er_q = exp_res.pop_front();
        idx = 0;
        while (exp_trace.size() > 0) begin
            e = exp_trace.pop_front();
            check($sformatf("%s.trace%0d", name, idx),
                  32'({busy_s, done_s, door_rs_s, btn_s}), 32'({2'b10, e}));
            if (abort && idx == 2) begin
                rs = 1'b0;
                #1;
                check({name, ".abort_out"},
                      32'({busy_s, done_s, door_rs_s, btn_s, result_s}), 32'(0));
                start = 1'b1; code = 8'hFF;
                repeat (3) @(negedge clk);
                start = 1'b0; rs = 1'b1;
                n = 0;
                repeat (15) begin
                    @(negedge clk);
                    if (done_s || busy_s) n++;
                end
                check({name, ".abort_quiet"}, 32'(n), 32'(0));
                check({name, ".abort_res"}, 32'({btn_s, result_s}), 32'({4'b0, RES_NONE}));
                exp_trace.delete();
                return;
            end
            if (poke) begin
                start = (idx == 1);
                code = 8'($urandom);
            end
            @(negedge clk);
            idx++;
        end
        start = 1'b0;
        waits = 0; bad = 1'b0;
        while (!done_s && waits < 60) begin
            if (btn_s != 4'b0 || !busy_s || door_rs_s) bad = 1'b1;
            @(negedge clk);
            waits++;
        end
        check({name, ".done"}, 32'(done_s), 32'(1));
        check({name, ".busy_at_done"}, 32'(busy_s), 32'(0));
        check({name, ".result"}, 32'(result_s), 32'(er_q));
        check({name, ".wait_quiet"}, 32'(bad), 32'(0));
        if (mode == LK_MUTE) check({name, ".timeout_len"}, 32'(waits), 32'(TIMEOUT_CYC));
        start = 1'b1; code = c;
        @(negedge clk);
        start = 1'b0;
        check({name, ".after_done"}, 32'({busy_s, done_s, door_rs_s, btn_s}), 32'(0));
        check({name, ".held"}, 32'(result_s), 32'(er_q));
    endtask

    initial begin
        lk_mode = LK_RAND; lk_clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'($urandom); code = 8'($urandom);
            #1;
            check($sformatf("reset%0d", i),
                  32'({btn0, door_rs0, busy0, done0, result0, btn1, door_rs1, busy1, done1, result1}),
                  32'(0));
        end
        @(negedge clk);
        start = 1'b0; rs = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 32'({busy0, done0, btn0, result0, busy1, done1, btn1, result1}), 32'(0));

        run_seq("pass",      1'b0, 8'hD8, LK_JUDGE, RES_PASS,    1'b0, 1'b0);
        run_seq("fail_poke", 1'b0, 8'hE4, LK_JUDGE, RES_FAIL,    1'b1, 1'b0);
        run_seq("timeout",   1'b0, 8'h4E, LK_MUTE,  RES_TIMEOUT, 1'b0, 1'b0);
        run_seq("both",      1'b0, 8'hD8, LK_BOTH,  RES_FAIL,    1'b0, 1'b0);
        run_seq("noise",     1'b0, 8'hD8, LK_NOISE, RES_PASS,    1'b0, 1'b0);
        run_seq("gap_pass",  1'b1, 8'hD8, LK_JUDGE, RES_PASS,    1'b0, 1'b0);
        run_seq("gap_tmo",   1'b1, 8'hE4, LK_MUTE,  RES_TIMEOUT, 1'b0, 1'b0);
        run_seq("gap_rep",   1'b1, 8'h00, LK_MUTE,  RES_TIMEOUT, 1'b0, 1'b0);
        run_seq("pre_abort", 1'b0, 8'hE4, LK_JUDGE, RES_FAIL,    1'b0, 1'b0);
        run_seq("abort",     1'b0, 8'hD8, LK_JUDGE, RES_NONE,    1'b0, 1'b1);
        run_seq("post_abort",1'b0, 8'hD8, LK_JUDGE, RES_PASS,    1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
